// File: rtl/collision_scheduler_if.sv
// Shared rectangle-overlap comparator bus: the scheduler (master) presents a
// ball/target pair, the comparator (slave) returns the collision result.
interface collision_scheduler_if #(
  parameter int unsigned X_POS_W = 10,
  parameter int unsigned Y_POS_W = 10
);
  logic [X_POS_W-1:0] cmp_r1_left_o;
  logic [X_POS_W-1:0] cmp_r1_right_o;
  logic [Y_POS_W-1:0] cmp_r1_top_o;
  logic [Y_POS_W-1:0] cmp_r1_bottom_o;
  logic [X_POS_W-1:0] cmp_r2_left_o;
  logic [X_POS_W-1:0] cmp_r2_right_o;
  logic [Y_POS_W-1:0] cmp_r2_top_o;
  logic [Y_POS_W-1:0] cmp_r2_bottom_o;
  logic               cmp_collision_i;

  modport master (
    output cmp_r1_left_o, cmp_r1_right_o, cmp_r1_top_o, cmp_r1_bottom_o,
    output cmp_r2_left_o, cmp_r2_right_o, cmp_r2_top_o, cmp_r2_bottom_o,
    input  cmp_collision_i
  );

  modport slave (
    input  cmp_r1_left_o, cmp_r1_right_o, cmp_r1_top_o, cmp_r1_bottom_o,
    input  cmp_r2_left_o, cmp_r2_right_o, cmp_r2_top_o, cmp_r2_bottom_o,
    output cmp_collision_i
  );
endinterface

// File: rtl/collision_scheduler.sv
// Time-multiplexes one pipelined rectangle comparator over N_TGT ball/target
// pairs per frame. Optional sticky overrun flag: COLLISION_SCHED_OVERRUN_EN.
module collision_scheduler #(
  parameter int unsigned X_POS_W = 10,
  parameter int unsigned Y_POS_W = 10,
  parameter int unsigned N_TGT   = 4,
  parameter int unsigned CMP_LAT = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       frame_start_i,
  input  logic [X_POS_W-1:0]         ball_left_i,
  input  logic [X_POS_W-1:0]         ball_right_i,
  input  logic [Y_POS_W-1:0]         ball_top_i,
  input  logic [Y_POS_W-1:0]         ball_bottom_i,
  input  logic [N_TGT*X_POS_W-1:0]   tgt_left_i,
  input  logic [N_TGT*X_POS_W-1:0]   tgt_right_i,
  input  logic [N_TGT*Y_POS_W-1:0]   tgt_top_i,
  input  logic [N_TGT*Y_POS_W-1:0]   tgt_bottom_i,
  input  logic [N_TGT-1:0]           tgt_en_i,
  collision_scheduler_if.master      cmp,
  output logic [N_TGT-1:0]           hit_o,
  output logic                       done_o,
  output logic                       busy_o,
  output logic                       overrun_o
);

  localparam int unsigned     IDX_W    = (N_TGT > 1) ? $clog2(N_TGT) : 1;
  localparam int unsigned     PIPE_D   = CMP_LAT + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TGT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [N_TGT-1:0]   acc_q;
  logic [PIPE_D-1:0]  pv_q;
  logic [PIPE_D-1:0]  pen_q;
  logic [IDX_W-1:0]   pidx_q [PIPE_D];

  logic               launch;
  logic [IDX_W-1:0]   launch_idx;
  logic [X_POS_W-1:0] sel_l, sel_r;
  logic [Y_POS_W-1:0] sel_t, sel_b;
  logic               sel_en;
  logic               cap_hit;
  logic               cap_last;
  logic [N_TGT-1:0]   acc_nxt;

  // Target selection for the pair launched this edge, and result capture
  always_comb begin
    launch     = ((state_q == IDLE) && frame_start_i) || (state_q == ISSUE);
    launch_idx = (state_q == ISSUE) ? idx_q : '0;
    sel_l  = '0;
    sel_r  = '0;
    sel_t  = '0;
    sel_b  = '0;
    sel_en = 1'b0;
    for (int unsigned k = 0; k < N_TGT; k++) begin
      if (launch_idx == IDX_W'(k)) begin
        sel_l  = tgt_left_i[k*X_POS_W +: X_POS_W];
        sel_r  = tgt_right_i[k*X_POS_W +: X_POS_W];
        sel_t  = tgt_top_i[k*Y_POS_W +: Y_POS_W];
        sel_b  = tgt_bottom_i[k*Y_POS_W +: Y_POS_W];
        sel_en = tgt_en_i[k];
      end
    end
    cap_hit  = pv_q[PIPE_D-1] & pen_q[PIPE_D-1] & cmp.cmp_collision_i;
    cap_last = pv_q[PIPE_D-1] && (pidx_q[PIPE_D-1] == LAST_IDX);
    acc_nxt  = acc_q;
    for (int unsigned k = 0; k < N_TGT; k++) begin
      if (cap_hit && (pidx_q[PIPE_D-1] == IDX_W'(k))) acc_nxt[k] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      pv_q    <= '0;
      pen_q   <= '0;
      for (int unsigned i = 0; i < PIPE_D; i++) pidx_q[i] <= '0;
      hit_o   <= '0;
      done_o  <= 1'b0;
      busy_o  <= 1'b0;
      cmp.cmp_r1_left_o   <= '0;
      cmp.cmp_r1_right_o  <= '0;
      cmp.cmp_r1_top_o    <= '0;
      cmp.cmp_r1_bottom_o <= '0;
      cmp.cmp_r2_left_o   <= '0;
      cmp.cmp_r2_right_o  <= '0;
      cmp.cmp_r2_top_o    <= '0;
      cmp.cmp_r2_bottom_o <= '0;
    end else begin
      done_o <= 1'b0;
      acc_q  <= acc_nxt;

      // Valid/index/enable shift pipeline tracking in-flight comparisons
      for (int unsigned i = PIPE_D - 1; i > 0; i--) begin
        pv_q[i]   <= pv_q[i-1];
        pen_q[i]  <= pen_q[i-1];
        pidx_q[i] <= pidx_q[i-1];
      end
      pv_q[0]   <= launch;
      pen_q[0]  <= launch & sel_en;
      pidx_q[0] <= launch_idx;

      if (launch) begin
        cmp.cmp_r1_left_o   <= ball_left_i;
        cmp.cmp_r1_right_o  <= ball_right_i;
        cmp.cmp_r1_top_o    <= ball_top_i;
        cmp.cmp_r1_bottom_o <= ball_bottom_i;
        cmp.cmp_r2_left_o   <= sel_l;
        cmp.cmp_r2_right_o  <= sel_r;
        cmp.cmp_r2_top_o    <= sel_t;
        cmp.cmp_r2_bottom_o <= sel_b;
      end

      case (state_q)
        IDLE: begin
          if (frame_start_i) begin
            acc_q   <= '0;
            idx_q   <= IDX_W'(1);
            busy_o  <= 1'b1;
            state_q <= (N_TGT == 1) ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= DRAIN;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DRAIN: begin
          if (cap_last) begin
            hit_o   <= acc_nxt;
            acc_q   <= '0;
            done_o  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef COLLISION_SCHED_OVERRUN_EN
  // Sticky record of a frame start that arrived while a round was running
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun_o <= 1'b0;
    end else if (frame_start_i && busy_o) begin
      overrun_o <= 1'b1;
    end
  end
`else
  assign overrun_o = 1'b0;
`endif

endmodule
